mem_port_arbiter: RTL and testbench

- Shares the CPU's single external memory port between instruction fetch (I) and data access (D).
- Sequences each transaction on an Avalon-style waitrequest handshake.
- Drives `grant_data`, the select line for the 32-bit address/data muxes in the datapath.
- Sits between the fetch/LSU stages and the top-level memory interface.

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_arb_pick.sv | 22 ++
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and grant codes for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory handshake bundle seen by the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readdata;
    logic              i_waitrequest;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [BE_W-1:0]   d_byteenable;
    logic [DATA_W-1:0] d_readdata;
    logic              d_waitrequest;

    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;
    logic [DATA_W-1:0] m_readdata;
    logic              m_waitrequest;

    // Arbiter view: consumes requests and memory responses, drives everything else.
    modport master (
        input  i_read, i_address,
        output i_readdata, i_waitrequest,
        input  d_read, d_write, d_address, d_writedata, d_byteenable,
        output d_readdata, d_waitrequest,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_readdata, m_waitrequest
    );

    modport slave (
        output i_read, i_address,
        input  i_readdata, i_waitrequest,
        output d_read, d_write, d_address, d_writedata, d_byteenable,
        input  d_readdata, d_waitrequest,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_readdata, m_waitrequest
    );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - combinational I/D grant select; ARB_ROUND_ROBIN_EN selects round-robin
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);
`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        if (req_i && req_d) grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        else                grant = req_d ? GRANT_D : GRANT_I;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Value with no request is don't-care; the FSM only samples it when a request exists.
    assign grant = (req_i && !req_d) ? GRANT_I : GRANT_D;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data; ARB_ROUND_ROBIN_EN enables fair arbitration
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus,
    output logic                 grant_data
);
    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
    logic              req_i, req_d, pick, last_grant;
    logic              done_i, done_d;

    logic [ADDR_W-1:0] m_address;
    logic              m_read, m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;

    assign req_i  = bus.i_read;
    assign req_d  = bus.d_read | bus.d_write;
    assign done_i = (state_q == BUSY_I) && req_i && !bus.m_waitrequest;
    assign done_d = (state_q == BUSY_D) && req_d && !bus.m_waitrequest;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              last_grant_q <= GRANT_I;
        else if (state_q == IDLE && (req_i || req_d)) last_grant_q <= pick;
    end
    assign last_grant = last_grant_q;
`else
    assign last_grant = GRANT_I;
`endif

    arb_pick u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_I;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (done_i) i_rdata_q <= bus.m_readdata;
            if (done_d) d_rdata_q <= bus.m_readdata;
        end
    end

    // The memory side is only driven from BUSY states, so reset drops strobes asynchronously.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        m_address    = '0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_writedata  = '0;
        m_byteenable = '0;
        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    grant_d = pick;
                    state_d = (pick == GRANT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                m_address    = bus.i_address;
                m_read       = bus.i_read;
                m_byteenable = '1;
                if (!req_i || !bus.m_waitrequest) state_d = IDLE;
            end
            BUSY_D: begin
                m_address    = bus.d_address;
                m_read       = bus.d_read & ~bus.d_write;
                m_write      = bus.d_write;
                m_writedata  = bus.d_writedata;
                m_byteenable = bus.d_byteenable;
                if (!req_d || !bus.m_waitrequest) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m_address     = m_address;
    assign bus.m_read        = m_read;
    assign bus.m_write       = m_write;
    assign bus.m_writedata   = m_writedata;
    assign bus.m_byteenable  = m_byteenable;

    assign bus.i_waitrequest = req_i & ~done_i;
    assign bus.d_waitrequest = req_d & ~done_d;
    assign bus.i_readdata    = done_i ? bus.m_readdata : i_rdata_q;
    assign bus.d_readdata    = done_d ? bus.m_readdata : d_rdata_q;
    assign grant_data        = grant_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter; honours ARB_ROUND_ROBIN_EN
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic grant_data;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .grant_data (grant_data)
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_read        = 1'b0;
        bus.i_address     = '0;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_address     = '0;
        bus.d_writedata   = '0;
        bus.d_byteenable  = '0;
        bus.m_readdata    = '0;
        bus.m_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    logic exp_g;

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        check_vec("rst_m_read", 32'(bus.m_read), 0);
        check_vec("rst_m_write", 32'(bus.m_write), 0);
        check_vec("rst_m_address", bus.m_address, 0);
        check_vec("rst_m_be", 32'(bus.m_byteenable), 0);
        check_vec("rst_grant", 32'(grant_data), 0);
        check_vec("rst_i_rdata", bus.i_readdata, 0);
        check_vec("rst_d_rdata", bus.d_readdata, 0);
        reset = 1'b0;

        // Single zero-wait instruction read
        bus.i_read = 1'b1; bus.i_address = 32'hBFC0_0000;
        bus.m_readdata = 32'h3C01_1234; bus.m_waitrequest = 1'b0;
        #1;
        check_vec("i_arb_wait", 32'(bus.i_waitrequest), 1);
        check_vec("i_arb_m_read", 32'(bus.m_read), 0);
        step();
        check_vec("i_done_wait", 32'(bus.i_waitrequest), 0);
        check_vec("i_done_rdata", bus.i_readdata, 32'h3C01_1234);
        check_vec("i_done_grant", 32'(grant_data), 0);
        check_vec("i_done_m_read", 32'(bus.m_read), 1);
        check_vec("i_done_addr", bus.m_address, 32'hBFC0_0000);
        check_vec("i_done_be", 32'(bus.m_byteenable), 32'hF);
        step();
        bus.i_read = 1'b0; bus.m_readdata = '0;
        #1;
        check_vec("i_hold_rdata", bus.i_readdata, 32'h3C01_1234);
        check_vec("i_idle_m_read", 32'(bus.m_read), 0);

        // Data write with three wait states
        bus.d_write = 1'b1; bus.d_address = 32'h0000_1000;
        bus.d_writedata = 32'hDEAD_BEEF; bus.d_byteenable = 4'b0011;
        bus.m_waitrequest = 1'b1;
        #1;
        check_vec("dw_arb_wait", 32'(bus.d_waitrequest), 1);
        check_vec("dw_arb_m_write", 32'(bus.m_write), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            bus.m_waitrequest = (k == 4) ? 1'b0 : 1'b1;
            #1;
            check_vec($sformatf("dw%0d_m_write", k), 32'(bus.m_write), 1);
            check_vec($sformatf("dw%0d_addr", k), bus.m_address, 32'h0000_1000);
            check_vec($sformatf("dw%0d_wdata", k), bus.m_writedata, 32'hDEAD_BEEF);
            check_vec($sformatf("dw%0d_be", k), 32'(bus.m_byteenable), 32'h3);
            check_vec($sformatf("dw%0d_grant", k), 32'(grant_data), 1);
            check_vec($sformatf("dw%0d_wait", k), 32'(bus.d_waitrequest), (k == 4) ? 0 : 1);
        end
        step();
        bus.d_write = 1'b0;
        #1;
        check_vec("dw_idle_m_write", 32'(bus.m_write), 0);
        check_vec("dw_idle_grant", 32'(grant_data), 1);

        // Four simultaneous I/D requests from a fresh reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.i_read = 1'b1; bus.i_address = 32'h0000_0100;
            bus.d_read = 1'b1; bus.d_address = 32'h0000_0200;
            bus.m_waitrequest = 1'b0;
            step();
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 0);
`else
            exp_g = 1'b1;
`endif
            check_vec($sformatf("sim%0d_grant", k), 32'(grant_data), 32'(exp_g));
            check_vec($sformatf("sim%0d_addr", k), bus.m_address, exp_g ? 32'h200 : 32'h100);
            step();
            bus.i_read = 1'b0; bus.d_read = 1'b0;
            step();
        end

        // I stalled by two waits while D requests
        bus.i_read = 1'b1; bus.i_address = 32'h0040_0000; bus.m_waitrequest = 1'b1;
        step();
        bus.d_read = 1'b1; bus.d_address = 32'h0000_3000;
        #1;
        check_vec("st_c1_addr", bus.m_address, 32'h0040_0000);
        check_vec("st_c1_grant", 32'(grant_data), 0);
        check_vec("st_c1_dwait", 32'(bus.d_waitrequest), 1);
        step();
        check_vec("st_c2_addr", bus.m_address, 32'h0040_0000);
        step();
        bus.m_waitrequest = 1'b0; bus.m_readdata = 32'h1111_2222;
        #1;
        check_vec("st_c3_iwait", 32'(bus.i_waitrequest), 0);
        check_vec("st_c3_rdata", bus.i_readdata, 32'h1111_2222);
        check_vec("st_c3_addr", bus.m_address, 32'h0040_0000);
        step();
        bus.i_read = 1'b0;
        #1;
        check_vec("st_idle_m_read", 32'(bus.m_read), 0);
        check_vec("st_idle_dwait", 32'(bus.d_waitrequest), 1);
        step();
        bus.m_readdata = 32'h3333_4444;
        #1;
        check_vec("st_d_grant", 32'(grant_data), 1);
        check_vec("st_d_addr", bus.m_address, 32'h0000_3000);
        check_vec("st_d_rdata", bus.d_readdata, 32'h3333_4444);
        check_vec("st_d_wait", 32'(bus.d_waitrequest), 0);
        step();
        bus.d_read = 1'b0;
        step();

        // Request dropped mid-transaction aborts
        bus.i_read = 1'b1; bus.i_address = 32'h0000_0040; bus.m_waitrequest = 1'b1;
        step();
        check_vec("ab_m_read", 32'(bus.m_read), 1);
        bus.i_read = 1'b0;
        #1;
        check_vec("ab_drop_m_read", 32'(bus.m_read), 0);
        check_vec("ab_i_rdata", bus.i_readdata, 32'h1111_2222);
        step();
        bus.d_write = 1'b1; bus.d_address = 32'h0000_0080; bus.m_waitrequest = 1'b0;
        step();
        check_vec("ab_next_grant", 32'(grant_data), 1);
        step();
        bus.d_write = 1'b0;
        step();

        // Asynchronous reset during a five-wait data read
        bus.d_read = 1'b1; bus.d_address = 32'h1234_0000; bus.m_waitrequest = 1'b1;
        step();
        step();
        check_vec("rr_c2_m_read", 32'(bus.m_read), 1);
        check_vec("rr_c2_grant", 32'(grant_data), 1);
        reset = 1'b1;
        #1;
        check_vec("rr_m_read", 32'(bus.m_read), 0);
        check_vec("rr_m_addr", bus.m_address, 0);
        check_vec("rr_grant", 32'(grant_data), 0);
        check_vec("rr_i_rdata", bus.i_readdata, 0);
        check_vec("rr_d_rdata", bus.d_readdata, 0);
        step();
        clear_inputs();
        reset = 1'b0;
        step();

        // Read and write together: write wins
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h0000_2000;
        bus.d_writedata = 32'h0BAD_F00D; bus.d_byteenable = 4'hF; bus.m_waitrequest = 1'b0;
        step();
        check_vec("rw_m_write", 32'(bus.m_write), 1);
        check_vec("rw_m_read", 32'(bus.m_read), 0);
        check_vec("rw_addr", bus.m_address, 32'h0000_2000);
        step();
        clear_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
